counter_n: RTL and testbench
============================

# counter_n

Parametrised synchronous up/down counter: the next generation of the team's 4/8-bit loadable counters. It adds a configurable width and modulus, a saturate-or-wrap mode, and a proper cascade-enable input, so wide counters are built by chaining instances rather than through hand-written enable logic. It sits alongside the existing counters as the default counting primitive for timers, address generators and event counters.

## Interface
Parameters:
- `WIDTH`, default 8: counter width in bits; legal range ≥ 1.
- `MAX`, default `2**WIDTH-1`: terminal value; the count range is 0..`MAX`. Legal range 1..`2**WIDTH-1`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `clear`, input, 1: reset; synchronous and active-high; highest priority.
- `load`, input, 1: parallel load of `v`.
- `enable`, input, 1: count enable.
- `cin`, input, 1: cascade count enable; tie to 1 when the instance is standalone.
- `up`, input, 1: count direction; 1 = up, 0 = down.
- `sat`, input, 1: boundary mode; 1 = saturate, 0 = wrap.
- `v`, input, `WIDTH`: load value.
- `q`, output, `WIDTH`: registered count.
- `rc0`, output, 1: ripple carry / terminal count; combinational.
- `ovf`, output, 1: boundary event flag; registered.

## Operation
- Per-edge priority: `clear` > `load` > count > hold.
- `clear`=1: `q`←0 and `ovf`←0.
- `load`=1: `q`←`v` when `v`≤`MAX`; otherwise `q`←`MAX` (clamped). `load` does not require `enable`. `ovf`←0.
- Count step occurs when `enable`=1 and `cin`=1 (step = `enable & cin`):
  - `up`=1, `q`<`MAX`: `q`←`q`+1.
  - `up`=1, `q`=`MAX`: this is a boundary event. With `sat`=1, `q` holds; with `sat`=0, `q`←0.
  - `up`=0, `q`>0: `q`←`q`−1.
  - `up`=0, `q`=0: this is a boundary event. With `sat`=1, `q` holds; with `sat`=0, `q`←`MAX`.
- No step: `q` holds.
- `rc0` = `cin & ((up & q==MAX) | (~up & q==0))`. It does not depend on `enable`, `load` or `sat`.
- `ovf` behaviour is selected by the configuration macro (see Configuration).
- Arithmetic is performed at `WIDTH` bits. `q` never exceeds `MAX`.
- Cascading requires `MAX`=`2**WIDTH-1` on every stage:
  - All stages share `enable`, `up`, `load` and `clear`.
  - Stage 0 has `cin`=1; stage k has `cin` = `rc0` of stage k−1.
  - The `rc0` of the last stage is the chain terminal count.
  - `v` is split across the stages by bit slice.

## Timing
- Reset values: `q`=0, `ovf`=0. `rc0` evaluates combinationally and is 1 after reset when `up`=0 and `cin`=1.
- Load latency: 1 cycle. `q` equals `v` (or `MAX` if clamped) after the edge on which `load`=1.
- Count latency: 1 cycle per step; the output is valid after the clock edge.
- `rc0` changes in the same cycle as `q`, `up` or `cin`; there is no registered delay. A cascade of N stages has an N-deep combinational `rc0` path.
- `clear` asserted mid-count or simultaneously with `load`: the clear wins, giving `q`=0 and `ovf`=0 on that edge.
- `load` and a count step on the same edge: the load wins and no boundary event is recorded.
- Changing `up` on the cycle where `q`=`MAX`: the step uses the sampled `up`. For example, `q`=`MAX` with `up`=0 steps to `MAX`−1.
- `WIDTH`=1, `MAX`=1: the counter toggles 0↔1 in wrap mode.

## Configuration
- Macro: `COUNTER_N_STICKY_OVF_EN`.
- Defined: `ovf` is sticky. It is set on the edge of any boundary event, in either wrap or saturate mode, and stays 1 until `clear` or `load`.
- Undefined: `ovf` is a one-cycle pulse. It is 1 for exactly the cycle after an edge that had a boundary event, and 0 otherwise.
- Ports are identical in both builds.

## Test plan
- Reset and clamped load (`WIDTH`=4, `MAX`=9):
  - `clear` for 1 cycle gives `q`=0, `ovf`=0.
  - `load` with `v`=12 gives `q`=9; `load` with `v`=5 gives `q`=5 regardless of `enable`.
- Wrap up/down (`MAX`=9, `sat`=0):
  - Counting up from 8 gives `q` sequence 9, 0, 1. `rc0`=1 only while `q`=9.
  - `ovf` pulses once after the 9→0 edge; with the macro it stays 1 until the next `load`.
  - Counting down from 1 gives 0, 9, 8.
- Saturate (`sat`=1):
  - Counting up at `q`=9 holds 9 for 3 cycles and records a boundary event.
  - Counting down at 0 holds 0.
  - Switching `up` to 1 at `q`=0 steps to 1.
- Priority:
  - `clear`+`load`+`enable` with `v`=7 gives `q`=0.
  - `load`+`enable` at `q`=9 with `up`=1 and `v`=3 gives `q`=3 with no `ovf`.
  - `enable`=0 holds `q` for 4 cycles.
- Cascade of two `WIDTH`=4 stages (8-bit, `MAX`=15 per stage):
  - Load 0x0F, count up once: the combined `q` is 0x10.
  - Load 0xFF, count up: the combined `q` is 0x00 and chain `rc0` was 1 the cycle before.
  - Load 0x10, count down: the combined `q` is 0x0F.
- Reset mid-operation:
  - Assert `clear` during a sustained up-count at `q`=6: the next `q` is 0.
  - Sticky `ovf` clears, and counting resumes 1, 2 after release.

Source files
------------

// File: rtl/counter_n.sv
// Parametrised synchronous up/down counter with clamped load, wrap/saturate modes and cascade enable.
// Build option: define COUNTER_N_STICKY_OVF_EN to make ovf sticky until clear/load; otherwise it is a one-cycle pulse.
module counter_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MAX   = (2 ** WIDTH) - 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             enable,
  input  logic             cin,
  input  logic             up,
  input  logic             sat,
  input  logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] q,
  output logic             rc0,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             at_top, at_bot, at_edge, step, boundary;

  // Terminal-count detection shared by rc0 and the boundary event
  always_comb begin
    at_top   = (q_q == MAX_V);
    at_bot   = (q_q == '0);
    at_edge  = (up & at_top) | (~up & at_bot);
    step     = enable & cin;
    boundary = step & at_edge;
    rc0      = cin & at_edge;
  end

  // Next-state: load beats count; a boundary either wraps or holds
  always_comb begin
    q_d = q_q;
`ifdef COUNTER_N_STICKY_OVF_EN
    ovf_d = ovf_q;
`else
    ovf_d = 1'b0;
`endif
    if (load) begin
      q_d   = (v > MAX_V) ? MAX_V : v;
      ovf_d = 1'b0;
    end else if (step) begin
      if (boundary) begin
        ovf_d = 1'b1;
        if (!sat) begin
          q_d = up ? '0 : MAX_V;
        end
      end else begin
        q_d = up ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_counter_n.sv
// Bench for counter_n: table-driven vectors on a WIDTH=4/MAX=9 instance, plus cascade and WIDTH=1 sequences.
module tb_counter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main unit: WIDTH=4, MAX=9
  logic       m_clear = 1'b0, m_load = 1'b0, m_en = 1'b0, m_cin = 1'b1, m_up = 1'b0, m_sat = 1'b0;
  logic [3:0] m_v = '0, m_q;
  logic       m_rc0, m_ovf;

  counter_n #(.WIDTH(4), .MAX(9)) dut (
    .clk(clk), .clear(m_clear), .load(m_load), .enable(m_en), .cin(m_cin),
    .up(m_up), .sat(m_sat), .v(m_v), .q(m_q), .rc0(m_rc0), .ovf(m_ovf)
  );

  // Two-stage 8-bit cascade
  logic       c_clear = 1'b0, c_load = 1'b0, c_en = 1'b0, c_up = 1'b1, c_sat = 1'b0;
  logic [7:0] c_v = '0;
  logic [3:0] c_q0, c_q1;
  logic       c_rc0_0, c_rc0_1, c_ovf0, c_ovf1;

  counter_n #(.WIDTH(4)) stage0 (
    .clk(clk), .clear(c_clear), .load(c_load), .enable(c_en), .cin(1'b1),
    .up(c_up), .sat(c_sat), .v(c_v[3:0]), .q(c_q0), .rc0(c_rc0_0), .ovf(c_ovf0)
  );
  counter_n #(.WIDTH(4)) stage1 (
    .clk(clk), .clear(c_clear), .load(c_load), .enable(c_en), .cin(c_rc0_0),
    .up(c_up), .sat(c_sat), .v(c_v[7:4]), .q(c_q1), .rc0(c_rc0_1), .ovf(c_ovf1)
  );

  // WIDTH=1 toggle unit
  logic t_clear = 1'b0, t_en = 1'b0;
  logic t_q, t_rc0, t_ovf;

  counter_n #(.WIDTH(1), .MAX(1)) dut1 (
    .clk(clk), .clear(t_clear), .load(1'b0), .enable(t_en), .cin(1'b1),
    .up(1'b1), .sat(1'b0), .v(1'b0), .q(t_q), .rc0(t_rc0), .ovf(t_ovf)
  );

  typedef struct {
    logic       clr, ld, en, cin, up, sat;
    logic [3:0] v;
    logic [3:0] q;
    logic       ovf_p, ovf_s;
    logic       rc0;
  } vec_t;

  typedef struct {
    string      name;
    int         unit;
    logic [7:0] q;
    logic       ovf;
    bit         chk_ovf;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic clr, ld, en, cin, up, sat, input logic [3:0] v,
                              input logic [3:0] q, input logic ovf_p, ovf_s, rc0);
    vec_t r;
    r.clr = clr; r.ld = ld; r.en = en; r.cin = cin; r.up = up; r.sat = sat; r.v = v;
    r.q = q; r.ovf_p = ovf_p; r.ovf_s = ovf_s; r.rc0 = rc0;
    return r;
  endfunction

  function automatic logic pick_ovf(input logic p, input logic s);
`ifdef COUNTER_N_STICKY_OVF_EN
    return s;
`else
    return p;
`endif
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pop one expectation after the active edge and compare against the selected unit
  task automatic retire();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 8'd1, 8'd0);
      return;
    end
    e = sb.pop_front();
    case (e.unit)
      0: begin
        check({e.name, ".q"}, {4'h0, m_q}, e.q);
        if (e.chk_ovf) check({e.name, ".ovf"}, {7'h0, m_ovf}, {7'h0, e.ovf});
      end
      1: check({e.name, ".q"}, {c_q1, c_q0}, e.q);
      default: begin
        check({e.name, ".q"}, {7'h0, t_q}, e.q);
        if (e.chk_ovf) check({e.name, ".ovf"}, {7'h0, t_ovf}, {7'h0, e.ovf});
      end
    endcase
  endtask

  task automatic push(input string name, input int unit, input logic [7:0] q,
                      input logic ovf, input bit chk_ovf);
    exp_t e;
    e.name = name; e.unit = unit; e.q = q; e.ovf = ovf; e.chk_ovf = chk_ovf;
    sb.push_back(e);
  endtask

  task automatic edge_and_retire();
    @(posedge clk);
    #1;
    retire();
  endtask

  // Cascade step: drive at negedge, optionally check chain rc0 before the edge
  task automatic casc(input string name, input logic ld, en, up, input logic [7:0] v,
                      input logic [7:0] exp_q, input bit chk_rc, input logic exp_rc);
    @(negedge clk);
    c_load = ld; c_en = en; c_up = up; c_v = v;
    #1;
    if (chk_rc) check({name, ".rc0"}, {7'h0, c_rc0_1}, {7'h0, exp_rc});
    push(name, 1, exp_q, 1'b0, 1'b0);
    edge_and_retire();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset of the main unit
    @(negedge clk);
    m_clear = 1'b1; m_up = 1'b0; m_cin = 1'b1;
    push("reset", 0, 8'd0, 1'b0, 1'b1);
    edge_and_retire();
    @(negedge clk);
    m_clear = 1'b0;
    #1;
    check("reset.rc0_down", {7'h0, m_rc0}, 8'd1);

    //              clr ld en cin up sat v     q  ovp ovs rc0
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 4'd12, 9, 0, 0, 0));  // clamped load
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 4'd5,  5, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 4'd8,  8, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 4'd0,  9, 0, 0, 0));  // wrap up
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 4'd0,  0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 4'd0,  1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 4'd1,  1, 0, 0, 0));  // wrap down
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 4'd0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 4'd0,  9, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 4'd0,  8, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 1, 4'd9,  9, 0, 0, 0));  // saturate up
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 4'd0,  9, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 4'd0,  9, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 4'd0,  9, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 4'd0,  0, 0, 0, 0));  // saturate down
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 4'd0,  0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 4'd0,  1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 0, 4'd7,  0, 0, 0, 0));  // priority
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 4'd9,  9, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 4'd3,  3, 0, 0, 1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 4'd0, 3, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 4'd9,  9, 0, 0, 0));  // cin gates step and rc0
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 4'd0,  9, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 4'd0,  0, 1, 1, 1));  // set ovf, then count to 6
    for (int i = 1; i <= 6; i++)
      vecs.push_back(mk(0, 0, 1, 1, 1, 0, 4'd0, 4'(i), 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, 4'd0,  0, 0, 0, 0));  // clear mid-count
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 4'd0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 4'd0,  2, 0, 0, 0));

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      @(negedge clk);
      m_clear = vecs[i].clr; m_load = vecs[i].ld; m_en = vecs[i].en;
      m_cin = vecs[i].cin; m_up = vecs[i].up; m_sat = vecs[i].sat; m_v = vecs[i].v;
      #1;
      check({nm, ".rc0"}, {7'h0, m_rc0}, {7'h0, vecs[i].rc0});
      push(nm, 0, {4'h0, vecs[i].q}, pick_ovf(vecs[i].ovf_p, vecs[i].ovf_s), 1'b1);
      edge_and_retire();
    end
    @(negedge clk);
    m_clear = 1'b0; m_load = 1'b0; m_en = 1'b0;

    // Cascade
    @(negedge clk);
    c_clear = 1'b1;
    push("casc_reset", 1, 8'h00, 1'b0, 1'b0);
    edge_and_retire();
    @(negedge clk);
    c_clear = 1'b0;
    casc("casc_ld0f", 1, 0, 1, 8'h0F, 8'h0F, 0, 0);
    casc("casc_up0f", 0, 1, 1, 8'h00, 8'h10, 1, 0);
    casc("casc_ldff", 1, 0, 1, 8'hFF, 8'hFF, 0, 0);
    casc("casc_upff", 0, 1, 1, 8'h00, 8'h00, 1, 1);
    casc("casc_ld10", 1, 0, 0, 8'h10, 8'h10, 0, 0);
    casc("casc_dn10", 0, 1, 0, 8'h00, 8'h0F, 1, 0);
    @(negedge clk);
    c_en = 1'b0;

    // WIDTH=1 toggle in wrap mode
    @(negedge clk);
    t_clear = 1'b1;
    push("w1_reset", 2, 8'd0, 1'b0, 1'b1);
    edge_and_retire();
    @(negedge clk);
    t_clear = 1'b0; t_en = 1'b1;
    push("w1_t1", 2, 8'd1, 1'b0, 1'b1);
    edge_and_retire();
    push("w1_t2", 2, 8'd0, 1'b1, 1'b1);
    edge_and_retire();
    push("w1_t3", 2, 8'd1, pick_ovf(1'b0, 1'b1), 1'b1);
    edge_and_retire();
    @(negedge clk);
    t_en = 1'b0;

    check("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
